// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetch into a small FIFO, one registered pixel per pix_en strobe.
// A single outstanding req/ack read keeps the FIFO topped up; underflow is sticky per frame.
module vga_pixel_fetch #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned FRAME_PIXELS = 480000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic              visible,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             discard;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PIX_W-1:0] mem [DEPTH];
  logic             pending;
  logic             push;
  logic             pop;

  assign pending = (state == REQ);
  assign push    = pending && mem_ack && !discard && !frame_start;
  assign pop     = pix_en && visible && !frame_start && (count != '0);

  // A frame_start during an unacked read cannot drop mem_req, so the read is
  // marked for discard and the address reset is deferred to its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      discard  <= 1'b0;
    end else if (frame_start) begin
      if (state == REQ && !mem_ack) begin
        discard <= 1'b1;
      end else begin
        state    <= IDLE;
        mem_req  <= 1'b0;
        mem_addr <= '0;
        discard  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if ((count + CNT_W'(pending)) < FULL) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            discard <= 1'b0;
            if (discard) begin
              state    <= IDLE;
              mem_addr <= '0;
            end else if (mem_addr == LAST_ADDR) begin
              state <= DONE;
            end else begin
              state    <= IDLE;
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      pix_out   <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      pix_out   <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pix_en) begin
        if (!visible) begin
          pix_out <= '0;
        end else if (count != '0) begin
          pix_out <= mem[rptr];
        end else begin
          pix_out   <= '0;
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a full-frame instance plus a 20-pixel-frame instance,
// each fed by a small req/ack memory responder returning data = addr[7:0].
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_en = 1'b0;
  logic        visible = 1'b0;

  logic        m_req, m_ack, m_uf;
  logic [18:0] m_addr;
  logic [7:0]  m_data, m_pix;
  logic        s_req, s_ack, s_uf;
  logic [18:0] s_addr;
  logic [7:0]  s_data, s_pix;

  int unsigned m_delay = 0;
  int unsigned m_wait;
  bit          m_hold_en = 1'b0;
  logic [18:0] m_hold_addr = '0;
  logic [18:0] s_last_ack;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vga_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_en(pix_en),
    .visible(visible), .mem_req(m_req), .mem_addr(m_addr), .mem_ack(m_ack),
    .mem_data(m_data), .pix_out(m_pix), .underflow(m_uf)
  );

  vga_pixel_fetch #(.FRAME_PIXELS(20)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_en(pix_en),
    .visible(visible), .mem_req(s_req), .mem_addr(s_addr), .mem_ack(s_ack),
    .mem_data(s_data), .pix_out(s_pix), .underflow(s_uf)
  );

  // Memory model for the full-frame instance: programmable latency and a per-address hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack  <= 1'b0;
      m_data <= '0;
      m_wait <= 0;
    end else begin
      m_ack <= 1'b0;
      if (m_req && !m_ack && !(m_hold_en && m_addr == m_hold_addr)) begin
        if (m_wait >= m_delay) begin
          m_ack  <= 1'b1;
          m_data <= m_addr[7:0];
          m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack      <= 1'b0;
      s_data     <= '0;
      s_last_ack <= '1;
    end else begin
      s_ack <= 1'b0;
      if (s_req && !s_ack) begin
        s_ack      <= 1'b1;
        s_data     <= s_addr[7:0];
        s_last_ack <= s_addr;
      end
    end
  end

  task automatic strobe(input logic vis, output logic [7:0] px);
    @(negedge clk);
    pix_en  = 1'b1;
    visible = vis;
    @(negedge clk);
    pix_en = 1'b0;
    px     = m_pix;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (m_req !== 1'b0) $display("FAIL reset_req: got %b want 0", m_req); else passes++;
    checks++; if (m_addr !== 19'd0) $display("FAIL reset_addr: got %0d want 0", m_addr); else passes++;
    checks++; if (m_pix !== 8'h00) $display("FAIL reset_pix: got %h want 00", m_pix); else passes++;
    checks++; if (m_uf !== 1'b0) $display("FAIL reset_uf: got %b want 0", m_uf); else passes++;
    checks++; if (dut.count !== 5'd0) $display("FAIL reset_count: got %0d want 0", dut.count); else passes++;
    checks++; if (s_req !== 1'b0) $display("FAIL reset_s_req: got %b want 0", s_req); else passes++;
  endtask

  task automatic test_fill();
    logic [18:0] seen[$];
    logic prev;
    int bad;
    prev = 1'b0;
    bad  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (m_req && !prev) seen.push_back(m_addr);
      prev = m_req;
    end
    checks++; if (seen.size() != 16) $display("FAIL fill_nreq: got %0d want 16", seen.size()); else passes++;
    foreach (seen[i]) if (seen[i] !== 19'(i)) bad++;
    checks++; if (bad != 0) $display("FAIL fill_addr_seq: got %0d wrong addresses want 0", bad); else passes++;
    checks++; if (m_req !== 1'b0) $display("FAIL fill_req_low: got %b want 0", m_req); else passes++;
    checks++; if (dut.count !== 5'd16) $display("FAIL fill_count: got %0d want 16", dut.count); else passes++;
    checks++; if (dut_s.count !== 5'd16) $display("FAIL fill_s_count: got %0d want 16", dut_s.count); else passes++;
  endtask

  task automatic test_stream();
    logic [7:0] px, bad_px, bad_exp;
    int bad;
    bad = 0;
    bad_px = '0;
    bad_exp = '0;
    for (int i = 0; i < 24; i++) begin
      strobe(1'b1, px);
      if (px !== 8'(i)) begin
        if (bad == 0) begin bad_px = px; bad_exp = 8'(i); end
        bad++;
      end
    end
    checks++; if (bad != 0) $display("FAIL stream_pix: got %h want %h (%0d bad)", bad_px, bad_exp, bad); else passes++;
    checks++; if (m_uf !== 1'b0) $display("FAIL stream_uf: got %b want 0", m_uf); else passes++;
    checks++; if (dut.count !== 5'd16) $display("FAIL stream_refill: got %0d want 16", dut.count); else passes++;
  endtask

  task automatic test_done_small();
    bit req_seen;
    int n;
    req_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_req) req_seen = 1'b1;
    end
    checks++; if (req_seen) $display("FAIL done_no_req: got 1 want 0"); else passes++;
    checks++; if (s_last_ack !== 19'd19) $display("FAIL done_last_addr: got %0d want 19", s_last_ack); else passes++;
    checks++; if (s_uf !== 1'b1) $display("FAIL done_s_uf: got %b want 1", s_uf); else passes++;
    pulse_fs();
    checks++; if (s_uf !== 1'b0) $display("FAIL fs_s_uf_clear: got %b want 0", s_uf); else passes++;
    checks++; if (dut.count !== 5'd0) $display("FAIL fs_flush: got %0d want 0", dut.count); else passes++;
    n = 0;
    while (!s_req && n < 20) begin @(negedge clk); n++; end
    checks++; if (!s_req || s_addr !== 19'd0) $display("FAIL done_restart: got req=%b addr=%0d want req=1 addr=0", s_req, s_addr); else passes++;
  endtask

  task automatic test_underflow();
    logic [7:0] px, bad_px;
    int idx, bad;
    bit hit;
    idx = 0; bad = 0; hit = 1'b0; bad_px = '0;
    repeat (100) @(negedge clk);
    m_delay = 10;
    for (int s = 0; s < 100 && !hit; s++) begin
      strobe(1'b1, px);
      if (m_uf === 1'b1) begin
        hit = 1'b1;
        checks++; if (px !== 8'h00) $display("FAIL uf_black: got %h want 00", px); else passes++;
      end else begin
        if (px !== 8'(idx)) begin
          if (bad == 0) bad_px = px;
          bad++;
        end
        idx++;
      end
    end
    checks++; if (!hit) $display("FAIL uf_reached: got 0 want 1"); else passes++;
    checks++; if (bad != 0) $display("FAIL uf_drain_pix: got %h first bad, %0d bad want 0", bad_px, bad); else passes++;
    for (int s = 0; s < 5; s++) strobe(1'b1, px);
    checks++; if (m_uf !== 1'b1) $display("FAIL uf_sticky: got %b want 1", m_uf); else passes++;
    pulse_fs();
    checks++; if (m_uf !== 1'b0) $display("FAIL uf_clear: got %b want 0", m_uf); else passes++;
    m_delay = 0;
  endtask

  task automatic test_blank();
    logic [7:0] px;
    int nz;
    nz = 0;
    repeat (150) @(negedge clk);
    checks++; if (dut.count !== 5'd16) $display("FAIL blank_pre_count: got %0d want 16", dut.count); else passes++;
    for (int s = 0; s < 256; s++) begin
      strobe(1'b0, px);
      if (px !== 8'h00) nz++;
    end
    checks++; if (nz != 0) $display("FAIL blank_pix: got %0d nonzero want 0", nz); else passes++;
    checks++; if (dut.count !== 5'd16) $display("FAIL blank_count: got %0d want 16", dut.count); else passes++;
    checks++; if (m_uf !== 1'b0) $display("FAIL blank_uf: got %b want 0", m_uf); else passes++;
    strobe(1'b1, px);
    checks++; if (px !== 8'h00) $display("FAIL blank_head0: got %h want 00", px); else passes++;
    strobe(1'b1, px);
    checks++; if (px !== 8'h01) $display("FAIL blank_head1: got %h want 01", px); else passes++;
  endtask

  task automatic test_flush_mid_req();
    logic [7:0] px;
    int n;
    m_hold_addr = 19'd7;
    m_hold_en   = 1'b1;
    pulse_fs();
    n = 0;
    while (!(m_req && m_addr == 19'd7) && n < 200) begin @(negedge clk); n++; end
    checks++; if (!(m_req && m_addr == 19'd7)) $display("FAIL flush_reach7: got req=%b addr=%0d want req=1 addr=7", m_req, m_addr); else passes++;
    checks++; if (dut.count !== 5'd7) $display("FAIL flush_pre_count: got %0d want 7", dut.count); else passes++;
    pulse_fs();
    checks++; if (m_req !== 1'b1 || m_addr !== 19'd7) $display("FAIL flush_hold: got req=%b addr=%0d want req=1 addr=7", m_req, m_addr); else passes++;
    checks++; if (dut.count !== 5'd0) $display("FAIL flush_count: got %0d want 0", dut.count); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (m_req !== 1'b1) $display("FAIL flush_req_kept: got %b want 1", m_req); else passes++;
    m_hold_en = 1'b0;
    n = 0;
    while (m_req && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!m_req && n < 20) begin @(negedge clk); n++; end
    checks++; if (!m_req || m_addr !== 19'd0) $display("FAIL flush_next_addr: got req=%b addr=%0d want req=1 addr=0", m_req, m_addr); else passes++;
    checks++; if (dut.count !== 5'd0) $display("FAIL flush_dropped: got %0d want 0", dut.count); else passes++;
    repeat (100) @(negedge clk);
    strobe(1'b1, px);
    checks++; if (px !== 8'h00) $display("FAIL flush_pix0: got %h want 00", px); else passes++;
    strobe(1'b1, px);
    checks++; if (px !== 8'h01) $display("FAIL flush_pix1: got %h want 01", px); else passes++;
  endtask

  task automatic test_async_reset();
    logic [7:0] px;
    int n;
    pulse_fs();
    repeat (100) @(negedge clk);
    m_hold_addr = 19'd18;
    m_hold_en   = 1'b1;
    for (int s = 0; s < 3; s++) strobe(1'b1, px);
    checks++; if (px !== 8'h02) $display("FAIL arst_pre_pix: got %h want 02", px); else passes++;
    n = 0;
    while (!(m_req && m_addr == 19'd18) && n < 50) begin @(negedge clk); n++; end
    checks++; if (!(m_req && m_addr == 19'd18)) $display("FAIL arst_in_req: got req=%b addr=%0d want req=1 addr=18", m_req, m_addr); else passes++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_req !== 1'b0) $display("FAIL arst_req: got %b want 0", m_req); else passes++;
    checks++; if (m_pix !== 8'h00) $display("FAIL arst_pix: got %h want 00", m_pix); else passes++;
    checks++; if (dut.count !== 5'd0) $display("FAIL arst_count: got %0d want 0", dut.count); else passes++;
    m_hold_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_done_small();
    test_underflow();
    test_blank();
    test_flush_mid_req();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
